llc_set_writeback: RTL and testbench

// - Write-side counterpart of the LLC set lookup. Owns the per-set working buffers: tags, states, owners, lines and evict way.
// - Exports those buffers to the lookup logic and applies field/word-granular updates from the LLC FSM.
// - Writes owner cache IDs into line words, which is the inverse of the lookup's owner-ID extraction.
// - On flush, drains every modified way (and the evict pointer) to the LLC SRAM arrays over a valid/ready write port.

---
 rtl/llc_set_writeback_pkg.sv | 48 ++++
 rtl/llc_set_writeback_dirty_pick.sv | 33 +++
 rtl/llc_set_writeback.sv | 225 ++++++++++++++++++++++
 tb/tb_llc_set_writeback.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_set_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llc_set_writeback_pkg
// Description : Shared types and constants for the LLC set write-back block.
// Revision    : 1.0 - initial release
// ============================================================================
package llc_set_writeback_pkg;

    // Geometry of one LLC set
    localparam int LLC_WAYS       = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int BITS_PER_WORD  = 32;
    localparam int CACHE_ID_WIDTH = 4;
    localparam int LLC_TAG_BITS   = 16;
    localparam int LLC_STATE_BITS = 3;
    localparam int LLC_WAY_BITS   = $clog2(LLC_WAYS);

    typedef logic [LLC_TAG_BITS-1:0]                         llc_tag_t;
    typedef logic [LLC_STATE_BITS-1:0]                       llc_state_t;
    typedef logic [WORDS_PER_LINE-1:0]                       owner_t;
    typedef logic [WORDS_PER_LINE-1:0][BITS_PER_WORD-1:0]    line_t;
    typedef logic [LLC_WAY_BITS-1:0]                         llc_way_t;
    typedef logic [CACHE_ID_WIDTH-1:0]                       cache_id_t;
    typedef logic [4:0]                                      llc_upd_mask_t;

    // Field-enable bit positions inside llc_upd_mask_t
    localparam int LLC_UPD_TAG     = 0;
    localparam int LLC_UPD_STATE   = 1;
    localparam int LLC_UPD_LINE    = 2;
    localparam int LLC_UPD_OWN_SET = 3;
    localparam int LLC_UPD_OWN_CLR = 4;

    // LLC line states
    localparam llc_state_t LLC_I = 3'd0;
    localparam llc_state_t LLC_V = 3'd1;
    localparam llc_state_t LLC_S = 3'd2;
    localparam llc_state_t LLC_D = 3'd3;

    localparam llc_way_t LLC_LAST_WAY = llc_way_t'(LLC_WAYS - 1);

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_FLUSH = 2'd1,
        WB_DONE  = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/llc_set_writeback_dirty_pick.sv
`default_nettype none
// ============================================================================
// Module      : llc_dirty_pick
// Description : Lowest-set-bit encoder over the per-way dirty vector. Reports
//               the selected way, whether any way is dirty, and whether the
//               selected way is the only one left.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_dirty_pick
    import llc_set_writeback_pkg::*;
(
    input  logic [LLC_WAYS-1:0] dirty_i,
    output llc_way_t            way_o,
    output logic                any_o,
    output logic                last_o
);

    localparam logic [LLC_WAYS-1:0] C_ONE = LLC_WAYS'(1);

    // Scan from the top so the lowest dirty index is the last one written
    always_comb begin
        way_o = '0;
        for (int i = LLC_WAYS - 1; i >= 0; i--) begin
            if (dirty_i[i]) begin
                way_o = llc_way_t'(i);
            end
        end
        any_o  = |dirty_i;
        last_o = any_o && ((dirty_i & (dirty_i - C_ONE)) == '0);
    end

endmodule
`default_nettype wire

// File: rtl/llc_set_writeback.sv
`default_nettype none
// ============================================================================
// Module      : llc_set_writeback
// Description : Per-set working buffers for the LLC. Captures a set from SRAM,
//               applies field/word-granular updates, and drains modified ways
//               plus the evict pointer back to SRAM on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_set_writeback
    import llc_set_writeback_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  llc_tag_t      rd_tags       [LLC_WAYS],
    input  llc_state_t    rd_states     [LLC_WAYS],
    input  owner_t        rd_owners     [LLC_WAYS],
    input  line_t         rd_lines      [LLC_WAYS],
    input  llc_way_t      rd_evict_way,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  llc_way_t      upd_way,
    input  llc_upd_mask_t upd_mask,
    input  owner_t        upd_word_mask,
    input  llc_tag_t      upd_tag,
    input  llc_state_t    upd_state,
    input  line_t         upd_line,
    input  cache_id_t     upd_owner_id,
    input  logic          evict_adv,
    input  logic          flush_start,
    output logic          flush_done,
    output logic          busy,
    output llc_tag_t      tags_buf      [LLC_WAYS],
    output llc_state_t    states_buf    [LLC_WAYS],
    output owner_t        owners_buf    [LLC_WAYS],
    output line_t         lines_buf     [LLC_WAYS],
    output llc_way_t      evict_way_buf,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic          wr_data_en,
    output llc_way_t      wr_way,
    output llc_tag_t      wr_tag,
    output llc_state_t    wr_state,
    output owner_t        wr_owner,
    output line_t         wr_line,
    output logic          wr_evict_en,
    output llc_way_t      wr_evict_way
);

    wb_state_e           state_q, state_d;
    llc_tag_t            tags_q   [LLC_WAYS];
    llc_tag_t            tags_d   [LLC_WAYS];
    llc_state_t          states_q [LLC_WAYS];
    llc_state_t          states_d [LLC_WAYS];
    owner_t              owners_q [LLC_WAYS];
    owner_t              owners_d [LLC_WAYS];
    line_t               lines_q  [LLC_WAYS];
    line_t               lines_d  [LLC_WAYS];
    llc_way_t            evict_q, evict_d;
    logic [LLC_WAYS-1:0] dirty_q, dirty_d;
    logic                evict_dirty_q, evict_dirty_d;

    llc_way_t            pick_way;
    logic                pick_any;
    logic                pick_last;
    logic                upd_fire;
    logic                beat_fire;

    llc_dirty_pick u_pick (
        .dirty_i (dirty_q),
        .way_o   (pick_way),
        .any_o   (pick_any),
        .last_o  (pick_last)
    );

    // Updates are only taken while idle and not loading; gated by rst so the
    // handshake is closed while reset is held.
    assign upd_ready = rst && (state_q == WB_IDLE) && !load_en;
    assign upd_fire  = upd_valid && upd_ready;
    assign beat_fire = wr_valid && wr_ready;
    assign busy      = (state_q == WB_FLUSH) || (state_q == WB_DONE);

    assign tags_buf      = tags_q;
    assign states_buf    = states_q;
    assign owners_buf    = owners_q;
    assign lines_buf     = lines_q;
    assign evict_way_buf = evict_q;

    // Buffer next-state: load, update, evict advance, and dirty retirement on write beats
    always_comb begin
        tags_d        = tags_q;
        states_d      = states_q;
        owners_d      = owners_q;
        lines_d       = lines_q;
        evict_d       = evict_q;
        dirty_d       = dirty_q;
        evict_dirty_d = evict_dirty_q;
        if (state_q == WB_IDLE) begin
            if (load_en) begin
                tags_d        = rd_tags;
                states_d      = rd_states;
                owners_d      = rd_owners;
                lines_d       = rd_lines;
                evict_d       = rd_evict_way;
                dirty_d       = '0;
                evict_dirty_d = 1'b0;
            end else begin
                if (upd_fire) begin
                    if (upd_mask[LLC_UPD_TAG]) begin
                        tags_d[upd_way] = upd_tag;
                    end
                    if (upd_mask[LLC_UPD_STATE]) begin
                        states_d[upd_way] = upd_state;
                    end
                    for (int w = 0; w < WORDS_PER_LINE; w++) begin
                        if (upd_mask[LLC_UPD_LINE] && upd_word_mask[w]) begin
                            lines_d[upd_way][w] = upd_line[w];
                        end
                        // Owner ID overlays the low bits after any line write
                        if (upd_mask[LLC_UPD_OWN_SET] && upd_word_mask[w]) begin
                            lines_d[upd_way][w][CACHE_ID_WIDTH-1:0] = upd_owner_id;
                            owners_d[upd_way][w] = 1'b1;
                        end else if (upd_mask[LLC_UPD_OWN_CLR] && upd_word_mask[w]) begin
                            owners_d[upd_way][w] = 1'b0;
                        end
                    end
                    if (|upd_mask) begin
                        dirty_d[upd_way] = 1'b1;
                    end
                end
                if (evict_adv) begin
                    evict_d       = (evict_q == LLC_LAST_WAY) ? '0 : evict_q + llc_way_t'(1);
                    evict_dirty_d = 1'b1;
                end
            end
        end else if ((state_q == WB_FLUSH) && beat_fire) begin
            if (wr_data_en) begin
                dirty_d[pick_way] = 1'b0;
            end
            if (wr_evict_en) begin
                evict_dirty_d = 1'b0;
            end
        end
    end

    // Flush FSM next-state and write-port outputs
    always_comb begin
        state_d      = state_q;
        wr_valid     = 1'b0;
        wr_data_en   = 1'b0;
        wr_evict_en  = 1'b0;
        wr_way       = '0;
        wr_tag       = '0;
        wr_state     = '0;
        wr_owner     = '0;
        wr_line      = '0;
        wr_evict_way = '0;
        flush_done   = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (flush_start) begin
                    state_d = WB_FLUSH;
                end
            end
            WB_FLUSH: begin
                if (pick_any || evict_dirty_q) begin
                    wr_valid    = 1'b1;
                    wr_data_en  = pick_any;
                    // The evict pointer rides on the final data beat, or alone if no way is dirty
                    wr_evict_en = pick_any ? (pick_last && evict_dirty_q) : 1'b1;
                    if (pick_any) begin
                        wr_way   = pick_way;
                        wr_tag   = tags_q[pick_way];
                        wr_state = states_q[pick_way];
                        wr_owner = owners_q[pick_way];
                        wr_line  = lines_q[pick_way];
                    end
                    if (wr_evict_en) begin
                        wr_evict_way = evict_q;
                    end
                    // Leave straight from the final beat so N dirty ways take N cycles
                    if (wr_ready && (!pick_any || pick_last)) begin
                        state_d = WB_DONE;
                    end
                end else begin
                    state_d = WB_DONE;
                end
            end
            WB_DONE: begin
                flush_done = 1'b1;
                state_d    = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

    // State and buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= WB_IDLE;
            for (int i = 0; i < LLC_WAYS; i++) begin
                tags_q[i]   <= '0;
                states_q[i] <= '0;
                owners_q[i] <= '0;
                lines_q[i]  <= '0;
            end
            evict_q       <= '0;
            dirty_q       <= '0;
            evict_dirty_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tags_q        <= tags_d;
            states_q      <= states_d;
            owners_q      <= owners_d;
            lines_q       <= lines_d;
            evict_q       <= evict_d;
            dirty_q       <= dirty_d;
            evict_dirty_q <= evict_dirty_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_llc_set_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_set_writeback
// Description : Self-checking bench for llc_set_writeback with a beat
//               scoreboard fed from a small reference model of the buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_set_writeback;
    import llc_set_writeback_pkg::*;

    typedef struct {
        logic       data_en;
        llc_way_t   way;
        llc_tag_t   tag;
        llc_state_t st;
        owner_t     own;
        line_t      line;
        logic       ev_en;
        llc_way_t   ev_way;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    llc_tag_t      rd_tags   [LLC_WAYS];
    llc_state_t    rd_states [LLC_WAYS];
    owner_t        rd_owners [LLC_WAYS];
    line_t         rd_lines  [LLC_WAYS];
    llc_way_t      rd_evict_way;
    logic          upd_valid;
    logic          upd_ready;
    llc_way_t      upd_way;
    llc_upd_mask_t upd_mask;
    owner_t        upd_word_mask;
    llc_tag_t      upd_tag;
    llc_state_t    upd_state;
    line_t         upd_line;
    cache_id_t     upd_owner_id;
    logic          evict_adv;
    logic          flush_start;
    logic          flush_done;
    logic          busy;
    llc_tag_t      tags_buf   [LLC_WAYS];
    llc_state_t    states_buf [LLC_WAYS];
    owner_t        owners_buf [LLC_WAYS];
    line_t         lines_buf  [LLC_WAYS];
    llc_way_t      evict_way_buf;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_data_en;
    llc_way_t      wr_way;
    llc_tag_t      wr_tag;
    llc_state_t    wr_state;
    owner_t        wr_owner;
    line_t         wr_line;
    logic          wr_evict_en;
    llc_way_t      wr_evict_way;

    // Reference model of the set
    llc_tag_t            m_tags   [LLC_WAYS];
    llc_state_t          m_states [LLC_WAYS];
    owner_t              m_owners [LLC_WAYS];
    line_t               m_lines  [LLC_WAYS];
    llc_way_t            m_ev;
    logic [LLC_WAYS-1:0] m_dirty;
    logic                m_ev_dirty;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    llc_set_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .load_en       (load_en),
        .rd_tags       (rd_tags),
        .rd_states     (rd_states),
        .rd_owners     (rd_owners),
        .rd_lines      (rd_lines),
        .rd_evict_way  (rd_evict_way),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_way       (upd_way),
        .upd_mask      (upd_mask),
        .upd_word_mask (upd_word_mask),
        .upd_tag       (upd_tag),
        .upd_state     (upd_state),
        .upd_line      (upd_line),
        .upd_owner_id  (upd_owner_id),
        .evict_adv     (evict_adv),
        .flush_start   (flush_start),
        .flush_done    (flush_done),
        .busy          (busy),
        .tags_buf      (tags_buf),
        .states_buf    (states_buf),
        .owners_buf    (owners_buf),
        .lines_buf     (lines_buf),
        .evict_way_buf (evict_way_buf),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data_en    (wr_data_en),
        .wr_way        (wr_way),
        .wr_tag        (wr_tag),
        .wr_state      (wr_state),
        .wr_owner      (wr_owner),
        .wr_line       (wr_line),
        .wr_evict_en   (wr_evict_en),
        .wr_evict_way  (wr_evict_way)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t pat_line(input int way, input int salt);
        line_t l;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            l[w] = {8'(salt), 8'(way), 8'(w), 8'hA5};
        end
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LLC_WAYS; i++) begin
            m_tags[i]   = '0;
            m_states[i] = '0;
            m_owners[i] = '0;
            m_lines[i]  = '0;
        end
        m_ev       = '0;
        m_dirty    = '0;
        m_ev_dirty = 1'b0;
    endtask

    task automatic set_rd(input int salt, input llc_way_t ev);
        for (int i = 0; i < LLC_WAYS; i++) begin
            rd_tags[i]   = llc_tag_t'(salt * 256 + i);
            rd_states[i] = LLC_S;
            rd_owners[i] = '0;
            rd_lines[i]  = pat_line(i, salt);
        end
        rd_evict_way = ev;
    endtask

    task automatic do_load();
        load_en = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0;
        for (int i = 0; i < LLC_WAYS; i++) begin
            m_tags[i]   = rd_tags[i];
            m_states[i] = rd_states[i];
            m_owners[i] = rd_owners[i];
            m_lines[i]  = rd_lines[i];
        end
        m_ev       = rd_evict_way;
        m_dirty    = '0;
        m_ev_dirty = 1'b0;
    endtask

    task automatic do_update(input llc_way_t way, input llc_upd_mask_t mask, input owner_t wm,
                             input llc_tag_t tag, input llc_state_t st, input line_t line,
                             input cache_id_t id, input logic adv);
        upd_valid = 1'b1; upd_way = way; upd_mask = mask; upd_word_mask = wm;
        upd_tag = tag; upd_state = st; upd_line = line; upd_owner_id = id; evict_adv = adv;
        #1;
        check_eq("upd_ready_idle", 128'(upd_ready), 128'(1'b1));
        @(posedge clk); #1;
        upd_valid = 1'b0; upd_mask = '0; evict_adv = 1'b0;
        if (mask[LLC_UPD_TAG])   m_tags[way]   = tag;
        if (mask[LLC_UPD_STATE]) m_states[way] = st;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (mask[LLC_UPD_LINE] && wm[w]) m_lines[way][w] = line[w];
            if (mask[LLC_UPD_OWN_SET] && wm[w]) begin
                m_lines[way][w][CACHE_ID_WIDTH-1:0] = id;
                m_owners[way][w] = 1'b1;
            end else if (mask[LLC_UPD_OWN_CLR] && wm[w]) begin
                m_owners[way][w] = 1'b0;
            end
        end
        if (mask != '0) m_dirty[way] = 1'b1;
        if (adv) begin
            m_ev       = (int'(m_ev) == LLC_WAYS - 1) ? '0 : llc_way_t'(int'(m_ev) + 1);
            m_ev_dirty = 1'b1;
        end
    endtask

    // Expected write beats from the model's dirty state, in drain order
    task automatic push_beats(output int nb);
        beat_t b;
        int    seen;
        nb   = 0;
        seen = 0;
        for (int i = 0; i < LLC_WAYS; i++) if (m_dirty[i]) nb++;
        for (int i = 0; i < LLC_WAYS; i++) begin
            if (m_dirty[i]) begin
                seen++;
                b.data_en = 1'b1;
                b.way     = llc_way_t'(i);
                b.tag     = m_tags[i];
                b.st      = m_states[i];
                b.own     = m_owners[i];
                b.line    = m_lines[i];
                b.ev_en   = (seen == nb) && m_ev_dirty;
                b.ev_way  = b.ev_en ? m_ev : '0;
                sb.push_back(b);
            end
        end
        if (nb == 0 && m_ev_dirty) begin
            b.data_en = 1'b0; b.way = '0; b.tag = '0; b.st = '0; b.own = '0; b.line = '0;
            b.ev_en   = 1'b1; b.ev_way = m_ev;
            sb.push_back(b);
            nb = 1;
        end
    endtask

    task automatic do_flush(input string name, input int stall_at, input int stall_len);
        int nb;
        int k;
        int exp_lat;
        push_beats(nb);
        exp_lat = (nb == 0) ? 2 : nb + 1 + stall_len;
        flush_start = 1'b1;
        @(posedge clk); #1;
        flush_start = 1'b0;
        k = 1;
        check_eq({name, "_busy"}, 128'(busy), 128'(1'b1));
        while (!flush_done && k <= 40) begin
            wr_ready = !(k >= stall_at && k < stall_at + stall_len);
            @(posedge clk); #1;
            k++;
        end
        wr_ready = 1'b1;
        check_eq({name, "_done_latency"}, 128'(k), 128'(exp_lat));
        check_eq({name, "_beats_left"}, 128'(sb.size()), 128'(0));
        @(posedge clk); #1;
        check_eq({name, "_done_pulse"}, 128'(flush_done), 128'(1'b0));
        check_eq({name, "_idle"}, 128'(busy), 128'(1'b0));
        m_dirty    = '0;
        m_ev_dirty = 1'b0;
    endtask

    // Write-port monitor: compares every valid beat against the scoreboard head,
    // which also proves the beat holds steady while stalled; pops on handshake
    always @(negedge clk) begin
        if (rst && wr_valid) begin
            check_eq("beat_expected", 128'(sb.size() != 0), 128'(1'b1));
            if (sb.size() != 0) begin
                check_eq("beat_data_en", 128'(wr_data_en), 128'(sb[0].data_en));
                if (sb[0].data_en) begin
                    check_eq("beat_way",   128'(wr_way),   128'(sb[0].way));
                    check_eq("beat_tag",   128'(wr_tag),   128'(sb[0].tag));
                    check_eq("beat_state", 128'(wr_state), 128'(sb[0].st));
                    check_eq("beat_owner", 128'(wr_owner), 128'(sb[0].own));
                    check_eq("beat_line",  128'(wr_line),  128'(sb[0].line));
                end
                check_eq("beat_evict_en", 128'(wr_evict_en), 128'(sb[0].ev_en));
                if (sb[0].ev_en) begin
                    check_eq("beat_evict_way", 128'(wr_evict_way), 128'(sb[0].ev_way));
                end
                if (wr_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; load_en = 1'b0; upd_valid = 1'b0; upd_way = '0; upd_mask = '0;
        upd_word_mask = '0; upd_tag = '0; upd_state = '0; upd_line = '0; upd_owner_id = '0;
        evict_adv = 1'b0; flush_start = 1'b0; wr_ready = 1'b1;
        set_rd(0, '0);
        model_clear();

        // Reset state
        #2;
        check_eq("rst_upd_ready", 128'(upd_ready), 128'(1'b0));
        check_eq("rst_wr_valid",  128'(wr_valid),  128'(1'b0));
        check_eq("rst_busy",      128'(busy),      128'(1'b0));
        check_eq("rst_tags0",     128'(tags_buf[0]), 128'(0));
        check_eq("rst_line15",    128'(lines_buf[15]), 128'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Tag/state update on way 3 then single-beat flush
        set_rd(1, llc_way_t'(2));
        do_load();
        check_eq("load_tag5", 128'(tags_buf[5]), 128'(16'h0105));
        do_update(llc_way_t'(3), 5'b00011, '0, 16'h002A, LLC_V, '0, '0, 1'b0);
        check_eq("upd_tag3",   128'(tags_buf[3]),   128'(16'h002A));
        check_eq("upd_state3", 128'(states_buf[3]), 128'(LLC_V));
        do_flush("t1", 0, 0);

        // Owner set / clear on way 1 of an all-ones line
        set_rd(2, '0);
        rd_lines[1] = {WORDS_PER_LINE{32'hFFFF_FFFF}};
        do_load();
        do_update(llc_way_t'(1), 5'b01000, 4'b0101, '0, '0, '0, cache_id_t'(5), 1'b0);
        check_eq("own_owners1", 128'(owners_buf[1]),   128'(4'b0101));
        check_eq("own_word0",   128'(lines_buf[1][0]), 128'(32'hFFFF_FFF5));
        check_eq("own_word1",   128'(lines_buf[1][1]), 128'(32'hFFFF_FFFF));
        check_eq("own_word2",   128'(lines_buf[1][2]), 128'(32'hFFFF_FFF5));
        do_update(llc_way_t'(1), 5'b10000, 4'b0001, '0, '0, '0, '0, 1'b0);
        check_eq("own_clr1",    128'(owners_buf[1]),   128'(4'b0100));
        do_flush("t2", 0, 0);

        // Dirty ways 0, 2, 7 with evict wrap from way 15
        set_rd(3, llc_way_t'(15));
        do_load();
        do_update(llc_way_t'(0), 5'b00100, 4'b0010, '0, '0, pat_line(9, 9), '0, 1'b0);
        do_update(llc_way_t'(2), 5'b00001, '0, 16'h2222, '0, '0, '0, 1'b0);
        do_update(llc_way_t'(7), 5'b00010, '0, '0, LLC_D, '0, '0, 1'b1);
        check_eq("evict_wrap", 128'(evict_way_buf), 128'(0));
        check_eq("line0_w1",   128'(lines_buf[0][1]), 128'(32'h0909_01A5));
        do_flush("t3", 0, 0);

        // Three beats with wr_ready low for three cycles on the second one
        set_rd(4, llc_way_t'(5));
        do_load();
        do_update(llc_way_t'(4),  5'b00001, '0, 16'h4444, '0, '0, '0, 1'b0);
        do_update(llc_way_t'(9),  5'b00001, '0, 16'h9999, '0, '0, '0, 1'b0);
        do_update(llc_way_t'(12), 5'b00001, '0, 16'hCCCC, '0, '0, '0, 1'b0);
        do_flush("t4", 2, 3);

        // Evict-only drain
        do_update('0, '0, '0, '0, '0, '0, '0, 1'b1);
        check_eq("evict_adv6", 128'(evict_way_buf), 128'(6));
        do_flush("t4e", 0, 0);

        // Same-cycle load and update: load wins, dirty cleared
        do_update(llc_way_t'(6), 5'b00001, '0, 16'h6666, '0, '0, '0, 1'b0);
        set_rd(5, llc_way_t'(1));
        load_en = 1'b1; upd_valid = 1'b1; upd_way = '0; upd_mask = 5'b00001; upd_tag = 16'hDEAD;
        #1;
        check_eq("load_upd_ready", 128'(upd_ready), 128'(1'b0));
        @(posedge clk); #1;
        load_en = 1'b0; upd_valid = 1'b0; upd_mask = '0;
        for (int i = 0; i < LLC_WAYS; i++) begin
            m_tags[i] = rd_tags[i]; m_states[i] = rd_states[i];
            m_owners[i] = rd_owners[i]; m_lines[i] = rd_lines[i];
        end
        m_ev = rd_evict_way; m_dirty = '0; m_ev_dirty = 1'b0;
        check_eq("load_tag0", 128'(tags_buf[0]), 128'(16'h0500));
        check_eq("load_tag6", 128'(tags_buf[6]), 128'(16'h0506));
        check_eq("load_ev",   128'(evict_way_buf), 128'(1));
        do_flush("t5", 0, 0);

        // Reset in the middle of a stalled flush
        do_update(llc_way_t'(1), 5'b00001, '0, 16'h1111, '0, '0, '0, 1'b0);
        do_update(llc_way_t'(3), 5'b00001, '0, 16'h3333, '0, '0, '0, 1'b0);
        begin
            int nb;
            push_beats(nb);
        end
        wr_ready = 1'b0;
        flush_start = 1'b1;
        @(posedge clk); #1;
        flush_start = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_wr_valid", 128'(wr_valid), 128'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_wr_valid",  128'(wr_valid),    128'(1'b0));
        check_eq("abort_busy",      128'(busy),        128'(1'b0));
        check_eq("abort_done",      128'(flush_done),  128'(1'b0));
        check_eq("abort_upd_ready", 128'(upd_ready),   128'(1'b0));
        check_eq("abort_tag1",      128'(tags_buf[1]), 128'(0));
        sb.delete();
        model_clear();
        @(posedge clk); #1;
        check_eq("abort_no_done", 128'(flush_done), 128'(1'b0));
        rst = 1'b1;
        wr_ready = 1'b1;
        do_flush("t6", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
